coprocessor_io_riscv_ctrl: RTL
==============================

// Module: coprocessor_io_riscv_ctrl
// PURPOSE
//  Avalon-MM slave output port driving control flags from the Nios host to the RISC-V coprocessor.
//  Companion to the read-only flags input port: host writes, coprocessor samples out_port.
//  Provides a level register, atomic set/clear, and timed strobe pulses with busy/overrun status.
// PARAMETERS
//  WIDTH         2   number of control flag bits on out_port (1..32)
//  RESET_VALUE   0   value of the level register after reset
//  PULSE_CYCLES  4   strobe length in clk cycles (1..255)
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      Avalon word offset
//  chipselect  in   1      Avalon select
//  write_n     in   1      Avalon write strobe, active low; write = chipselect & ~write_n
//  writedata   in   32     Avalon write data; bits above WIDTH ignored
//  readdata    out  32     Avalon read data, registered, unused bits zero
//  out_port    out  WIDTH  flags to coprocessor = level_reg | pulse_reg
// BEHAVIOUR
//  Register map (word offsets):
//   0 DATA    R/W  level_reg; write loads writedata[WIDTH-1:0]
//   1 -       RO   reads 0; writes ignored
//   2 PULSE   WO   write loads pulse_reg and starts timer; reads 0
//   3 STATUS  R/W1C [0]=busy, [1]=overrun sticky, [15:8]=remaining count; write 1 to [1] clears overrun
//   4 OUTSET  WO   level_reg <= level_reg | wd; reads 0
//   5 OUTCLR  WO   level_reg <= level_reg & ~wd; reads 0
//   6,7       RO   read 0; writes ignored
//  Reset: level_reg=RESET_VALUE, pulse_reg=0, count=0, overrun=0, readdata=0; out_port=RESET_VALUE.
//  Write effects visible on out_port the cycle after the write cycle (1-cycle latency).
//  Read: readdata <= mux(address) every cycle regardless of chipselect; read latency 1.
//  Pulse timer: busy = (count != 0).
//   idle & PULSE write with wd!=0: pulse_reg<=wd, count<=PULSE_CYCLES.
//   PULSE write with wd==0: no effect, no overrun.
//   busy: count decrements each cycle; when count==1, next cycle count=0 and pulse_reg=0.
//   out_port pulse bits therefore high for exactly PULSE_CYCLES cycles.
//   PULSE write while busy (including count==1): ignored, overrun<=1.
//   overrun set and W1C clear in the same cycle: set wins.
//  Pulse and level overlap: out_port bit stays high if either source is high; no glitch at pulse end.
//  reset_n asserted mid-pulse: pulse aborts immediately, out_port=RESET_VALUE asynchronously.
//  Count field wider than 8 bits is not supported; PULSE_CYCLES>255 is a static error.
// STRUCTURE
//  Shared package coprocessor_io_pkg: localparams for offsets ADDR_DATA..ADDR_OUTCLR,
//   STATUS bit positions (ST_BUSY=0, ST_OVR=1, ST_CNT_LSB=8).
//  Sub-module coprocessor_io_pulse_timer: load/start, count, busy, overrun, pulse_reg;
//   top holds the Avalon decode, level_reg, and readdata mux.
// TESTING
//  1 Reset with RESET_VALUE=2'b01 -> out_port=01, read DATA=0x1, STATUS=0.
//  2 Write DATA=3, OUTCLR=1, OUTSET=0 -> out_port 11 then 10 then 10, each 1 cycle after write.
//  3 PULSE=2'b01 with level=00 -> out_port[0] high exactly 4 cycles; STATUS busy=1, cnt 4..1, then 0.
//  4 PULSE=01 then PULSE=10 two cycles later -> second ignored, only bit0 pulses, STATUS=0x2 after.
//  5 Write STATUS=0x2 after overrun -> overrun=0; PULSE=0 -> no pulse, overrun stays 0.
//  6 reset_n low mid-pulse (cnt=2) -> out_port=RESET_VALUE at once; after release busy=0, no pulse.

Source files
------------

// File: rtl/coprocessor_io_pkg.sv
// Shared register map and STATUS field positions for the coprocessor I/O ports.
package coprocessor_io_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PULSE  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR = 3'd5;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_OVR     = 1;
  localparam int unsigned ST_CNT_LSB = 8;

endpackage

// File: rtl/coprocessor_io_pulse_timer.sv
// Strobe generator: holds pulse bits high for PULSE_CYCLES clocks, flags overruns.
module coprocessor_io_pulse_timer
  import coprocessor_io_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] pulse_reg,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             overrun
);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse_cycles
    $error("PULSE_CYCLES must be in 1..255");
  end

  logic running_c;
  logic start_c;
  logic reject_c;

  // A zero-data strobe is a no-op and never counts as an overrun.
  assign running_c = (count != '0);
  assign start_c   = load && (load_data != '0) && !running_c;
  assign reject_c  = load && (load_data != '0) && running_c;

  // Countdown, pulse bits and sticky overrun; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_reg <= '0;
      count     <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start_c) begin
        pulse_reg <= load_data;
        count     <= CNT_W'(PULSE_CYCLES);
        busy      <= 1'b1;
      end else if (running_c) begin
        count <= count - CNT_W'(1);
        busy  <= (count != CNT_W'(1));
        if (count == CNT_W'(1)) begin
          pulse_reg <= '0;
        end
      end
      if (reject_c) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coprocessor_io_riscv_ctrl.sv
// Avalon-MM control-flag output port from the Nios host to the RISC-V coprocessor.
module coprocessor_io_riscv_ctrl
  import coprocessor_io_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter logic [31:0] RESET_VALUE  = 32'd0,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic             wr_c;
  logic [WIDTH-1:0] wd_c;
  logic             unused_wd_c;
  logic [WIDTH-1:0] level_reg;
  logic [WIDTH-1:0] pulse_reg;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             overrun;
  logic [DATA_W-1:0] rd_next_c;

  assign wr_c        = chipselect && !write_n;
  assign wd_c        = writedata[WIDTH-1:0];
  assign unused_wd_c = ^writedata;

  coprocessor_io_pulse_timer #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (wr_c && (address == ADDR_PULSE)),
    .load_data (wd_c),
    .ovr_clr   (wr_c && (address == ADDR_STATUS) && writedata[ST_OVR]),
    .pulse_reg (pulse_reg),
    .count     (count),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Level register: direct load plus atomic set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg <= WIDTH'(RESET_VALUE);
    end else if (wr_c) begin
      case (address)
        ADDR_DATA:   level_reg <= wd_c;
        ADDR_OUTSET: level_reg <= level_reg | wd_c;
        ADDR_OUTCLR: level_reg <= level_reg & ~wd_c;
        default:     level_reg <= level_reg;
      endcase
    end
  end

  // Read mux; write-only and reserved offsets return zero.
  always_comb begin
    rd_next_c = '0;
    case (address)
      ADDR_DATA: rd_next_c = DATA_W'(level_reg);
      ADDR_STATUS: begin
        rd_next_c[ST_BUSY]              = busy;
        rd_next_c[ST_OVR]               = overrun;
        rd_next_c[ST_CNT_LSB +: CNT_W]  = count;
      end
      default: rd_next_c = '0;
    endcase
  end

  // Registered read data, updated every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next_c;
    end
  end

  assign out_port = level_reg | pulse_reg;

endmodule
